vga_pixel_feeder: RTL and testbench
===================================

// Module: vga_pixel_feeder
// PURPOSE
//  Pixel-clock-domain stage directly upstream of the VGA timing generator. Pops framebuffer
//  words from the read side of the pixel FIFO (show-ahead), unpacks them to 24-bit RGB and
//  delivers one pixel per active-area request. Keeps frame alignment: starts streaming only
//  on a frame boundary, and after an underflow discards the rest of the frame to resynchronise.
// PARAMETERS
//  HDISP            800        active pixels per line
//  VDISP            480        active lines per frame
//  UNDERFLOW_COLOR  24'hFF00FF colour emitted for requests that cannot be served
//  (localparam FRAME_WORDS = HDISP*VDISP; word counter width $clog2(FRAME_WORDS+1))
// PORTS
//  pixel_clk        in   1   pixel clock; all logic on rising edge
//  pixel_rst        in   1   asynchronous, active-high reset
//  fifo_rdata       in   32  FIFO head word {8'hxx, R[7:0], G[7:0], B[7:0]}, valid when !fifo_rempty
//  fifo_rempty      in   1   FIFO empty
//  fifo_ralmost_full in  1   FIFO level above fill threshold
//  fifo_read        out  1   pop strobe (combinational, never asserted when fifo_rempty)
//  pix_req          in   1   timing generator needs an active pixel on rgb next cycle
//  frame_start      in   1   1-cycle pulse, first cycle of a frame (before first pix_req)
//  rgb              out  24  pixel colour, registered
//  rgb_valid        out  1   rgb holds a pixel answering the previous cycle's pix_req
//  underflow        out  1   sticky: a request hit an empty FIFO in STREAM
//  clr_err          in   1   synchronous clear of underflow (and stats counter)
// BEHAVIOUR
//  - Reset: state=FILL, rgb=0, rgb_valid=0, underflow=0, word_cnt=0, fifo_read=0.
//  - Latency: pix_req at cycle t -> rgb/rgb_valid at t+1; pix_req=0 -> rgb_valid=0 next cycle, rgb=0.
//  - FILL: no pops; rgb=0 on requests; -> WAIT_FRAME when fifo_ralmost_full.
//  - WAIT_FRAME: no pops; -> STREAM on frame_start. A pix_req coincident with frame_start
//    belongs to the new frame and is served in that same cycle.
//  - STREAM: on pix_req & !fifo_rempty: fifo_read=1, rgb<=fifo_rdata[23:0], word_cnt+1.
//    On pix_req & fifo_rempty: rgb<=UNDERFLOW_COLOR, underflow<=1, -> DRAIN.
//    frame_start clears word_cnt (to 1 if a pix_req is served the same cycle).
//  - DRAIN: fifo_read = !fifo_rempty every cycle (pix_req ignored for popping), word_cnt+1
//    per pop; all requests answered with UNDERFLOW_COLOR. When word_cnt reaches FRAME_WORDS
//    -> WAIT_FRAME (word_cnt cleared). frame_start during DRAIN does not reset word_cnt.
//  - word_cnt never exceeds FRAME_WORDS; popping stops at FRAME_WORDS in DRAIN.
//  - clr_err coincident with a new underflow: set wins.
//  - Reset mid-frame: block returns to FILL; FIFO contents are not flushed by this block.
// CONFIGURATION
//  VGA_FEEDER_STATS_EN defined: adds output underflow_cnt[15:0], +1 per STREAM->DRAIN event,
//  saturates at 16'hFFFF, cleared by clr_err or reset. Undefined: port and counter absent,
//  all other behaviour identical.
// STRUCTURE
//  video_pkg: typedef rgb_t (logic [23:0]), feeder_state_t enum {FILL, WAIT_FRAME, STREAM,
//  DRAIN}, default UNDERFLOW_COLOR constant. Stats counter in sub-module vga_feeder_stats
//  (instantiated only under VGA_FEEDER_STATS_EN). Everything else in one module.
// TESTING (HDISP=8, VDISP=4 for bench speed)
//  - FIFO preloaded 32 words 0x00000001..0x20, almost_full=1, frame_start then 32 pix_req
//    -> rgb sequence 0x000001..0x000020, each one cycle after its request, underflow=0.
//  - pix_req before almost_full / before frame_start -> fifo_read=0, rgb=0, FIFO untouched.
//  - FIFO empties after 10 pixels mid-frame -> pixel 11 = 0xFF00FF, underflow=1, then 22
//    further words popped regardless of pix_req, state WAIT_FRAME; next frame aligned to word 0.
//  - frame_start and pix_req in same cycle from WAIT_FRAME -> first word popped that cycle.
//  - pixel_rst asserted mid-STREAM -> all outputs 0 immediately, FILL on release; clr_err
//    clears underflow; clr_err with new underflow same cycle -> underflow stays 1.
//  - VGA_FEEDER_STATS_EN: 3 underflow frames -> underflow_cnt=3; clr_err -> 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video types for the pixel-clock domain.
//   rgb_t                : 24-bit {R,G,B} pixel
//   feeder_state_t       : vga_pixel_feeder state encoding
//   UNDERFLOW_COLOR_DEF  : default colour for requests that cannot be served
package video_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        FILL,
        WAIT_FRAME,
        STREAM,
        DRAIN
    } feeder_state_t;

    localparam rgb_t UNDERFLOW_COLOR_DEF = 24'hFF00FF;

endpackage

// File: rtl/vga_feeder_stats.sv
// Saturating underflow event counter for vga_pixel_feeder.
//   pixel_clk, pixel_rst : clock, async active-high reset
//   clr                  : synchronous clear
//   inc                  : one STREAM->DRAIN event this cycle
//   underflow_cnt        : event count, saturates at 16'hFFFF
module vga_feeder_stats (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] underflow_cnt
);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            underflow_cnt <= '0;
        end else if (clr) begin
            // an event in the clearing cycle is still counted
            underflow_cnt <= {15'd0, inc};
        end else if (inc && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Pixel-clock stage feeding the VGA timing generator from a show-ahead FIFO.
// Pops one framebuffer word per active-area request, unpacks it to RGB and
// keeps frame alignment: streaming starts only on frame_start, and after an
// underflow the rest of the frame is discarded from the FIFO.
//   fifo_rdata/fifo_rempty/fifo_ralmost_full : FIFO read side (head word)
//   fifo_read    : combinational pop strobe
//   pix_req      : pixel wanted on rgb next cycle
//   frame_start  : first cycle of a frame
//   rgb/rgb_valid: registered pixel answering last cycle's pix_req
//   underflow    : sticky underflow flag, cleared by clr_err
//   underflow_cnt: only when VGA_FEEDER_STATS_EN is defined
module vga_pixel_feeder
    import video_pkg::*;
#(
    parameter int   HDISP           = 800,
    parameter int   VDISP           = 480,
    parameter rgb_t UNDERFLOW_COLOR = UNDERFLOW_COLOR_DEF
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [31:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_ralmost_full,
    output logic        fifo_read,
    input  logic        pix_req,
    input  logic        frame_start,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic        underflow,
    input  logic        clr_err
`ifdef VGA_FEEDER_STATS_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int FRAME_WORDS = HDISP * VDISP;
    localparam int CW          = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0] FW_C  = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    feeder_state_t state, state_nxt;
    logic [CW-1:0] word_cnt, cnt_nxt;
    rgb_t          rgb_nxt;
    logic          uf_evt;
    logic          streaming;

    // pad byte of the framebuffer word is not displayed
    logic unused_pad;
    assign unused_pad = ^fifo_rdata[31:24];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = word_cnt;
        rgb_nxt   = '0;
        fifo_read = 1'b0;
        uf_evt    = 1'b0;
        // a request coincident with frame_start belongs to the new frame
        streaming = (state == STREAM) || ((state == WAIT_FRAME) && frame_start);
        case (state)
            FILL: begin
                if (fifo_ralmost_full) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME, STREAM: begin
                if (streaming) begin
                    state_nxt = STREAM;
                    if (frame_start) cnt_nxt = '0;
                    if (pix_req) begin
                        if (!fifo_rempty) begin
                            fifo_read = 1'b1;
                            rgb_nxt   = fifo_rdata[23:0];
                            if (cnt_nxt < FW_C) cnt_nxt = cnt_nxt + ONE_C;
                        end else begin
                            rgb_nxt   = UNDERFLOW_COLOR;
                            uf_evt    = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // discard the remainder of the frame regardless of requests
                if (pix_req) rgb_nxt = UNDERFLOW_COLOR;
                if (!fifo_rempty && (word_cnt < FW_C)) begin
                    fifo_read = 1'b1;
                    cnt_nxt   = word_cnt + ONE_C;
                end
                if (cnt_nxt == FW_C) begin
                    state_nxt = WAIT_FRAME;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state     <= FILL;
            word_cnt  <= '0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= cnt_nxt;
            rgb       <= rgb_nxt;
            rgb_valid <= pix_req;
            if (uf_evt)       underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

`ifdef VGA_FEEDER_STATS_EN
    vga_feeder_stats u_stats (
        .pixel_clk     (pixel_clk),
        .pixel_rst     (pixel_rst),
        .clr           (clr_err),
        .inc           (uf_evt),
        .underflow_cnt (underflow_cnt)
    );
`endif

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Self-checking bench for vga_pixel_feeder (HDISP=8, VDISP=4).
// FIFO modelled as an array with read/write pointers; expected pixels come
// from the frame rules: request k of a frame gets FIFO word k while words
// remain, otherwise the underflow colour; a drained frame consumes exactly
// FRAME_WORDS words.
module tb_vga_pixel_feeder;
    import video_pkg::*;

    localparam int HD = 8;
    localparam int VD = 4;
    localparam int FW = HD * VD;
    localparam logic [23:0] UFC = 24'hFF00FF;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic [31:0] fifo_rdata;
    logic        fifo_rempty, fifo_ralmost_full, fifo_read;
    logic        pix_req, frame_start, clr_err;
    logic [23:0] rgb;
    logic        rgb_valid, underflow;
`ifdef VGA_FEEDER_STATS_EN
    logic [15:0] underflow_cnt;
    int          exp_cnt = 0;
`endif

    logic [31:0] mem [0:1023];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int bad_pop = 0;

    int          vectors = 0;
    int          miscompares = 0;
    logic        prev_req = 1'b0;
    logic [23:0] prev_exp = '0;
    logic        exp_uf = 1'b0;

    assign fifo_rempty = (rd_ptr == wr_ptr);
    assign fifo_rdata  = mem[rd_ptr % 1024];

    always @(posedge pixel_clk) begin
        if (fifo_read) begin
            if (fifo_rempty) bad_pop <= bad_pop + 1;
            rd_ptr <= rd_ptr + 1;
        end
    end

    always #5 pixel_clk = ~pixel_clk;

    vga_pixel_feeder #(.HDISP(HD), .VDISP(VD), .UNDERFLOW_COLOR(UFC)) dut (
        .pixel_clk         (pixel_clk),
        .pixel_rst         (pixel_rst),
        .fifo_rdata        (fifo_rdata),
        .fifo_rempty       (fifo_rempty),
        .fifo_ralmost_full (fifo_ralmost_full),
        .fifo_read         (fifo_read),
        .pix_req           (pix_req),
        .frame_start       (frame_start),
        .rgb               (rgb),
        .rgb_valid         (rgb_valid),
        .underflow         (underflow),
        .clr_err           (clr_err)
`ifdef VGA_FEEDER_STATS_EN
        ,
        .underflow_cnt     (underflow_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr++;
    endtask

    // apply one cycle of inputs and record what the outputs must be after the edge
    task automatic drive(input logic req, input logic fs, input logic clr,
                         input logic [23:0] pix, input logic uf);
        pix_req     = req;
        frame_start = fs;
        clr_err     = clr;
        prev_req    = req;
        prev_exp    = req ? pix : 24'h0;
        if (uf)       exp_uf = 1'b1;
        else if (clr) exp_uf = 1'b0;
`ifdef VGA_FEEDER_STATS_EN
        if (clr) exp_cnt = uf ? 1 : 0;
        else     exp_cnt = exp_cnt + (uf ? 1 : 0);
`endif
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
        chk("rgb_valid", {31'd0, rgb_valid}, {31'd0, prev_req});
        chk("rgb", {8'd0, rgb}, {8'd0, prev_exp});
        chk("underflow", {31'd0, underflow}, {31'd0, exp_uf});
`ifdef VGA_FEEDER_STATS_EN
        chk("underflow_cnt", {16'd0, underflow_cnt}, exp_cnt);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
            step();
        end
    endtask

    // one frame of nreq requests with random gaps
    task automatic run_frame(input int nreq, input bit coinc, input bit clr_on_uf);
        int   avail = wr_ptr - rd_ptr;
        int   base  = rd_ptr;
        int   i     = 0;
        bit   first = 1'b1;
        logic req, uf;
        logic [23:0] pix;
        logic [31:0] w;
        while (i < nreq) begin
            if (first) req = coinc;
            else       req = ($urandom_range(0, 3) != 0);
            pix = 24'h0;
            uf  = 1'b0;
            if (req) begin
                w   = mem[(base + i) % 1024];
                pix = (i < avail) ? w[23:0] : UFC;
                uf  = (i == avail);
            end
            drive(req, first, uf && clr_on_uf, pix, uf);
            #1;
            chk("fifo_read", {31'd0, fifo_read}, {31'd0, req && (i < avail)});
            step();
            if (req) i++;
            first = 1'b0;
        end
    endtask

    // supply the words still owed by an underflowed frame plus extra next-frame words
    task automatic drain_chk(input int owed, input int extra);
        int k = 0;
        repeat (owed + extra) push($urandom);
        while (((wr_ptr - rd_ptr) > extra) && (k < 100)) begin
            idle(1);
            k++;
        end
        idle(5);
        chk("drain_left", wr_ptr - rd_ptr, extra);
    endtask

    initial begin
        int n;
        pixel_rst = 1'b1;
        pix_req = 1'b0; frame_start = 1'b0; clr_err = 1'b0; fifo_ralmost_full = 1'b0;
        #12;
        chk("rst_rgb", {8'd0, rgb}, 32'd0);
        chk("rst_rgb_valid", {31'd0, rgb_valid}, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
        @(posedge pixel_clk);
        #1 pixel_rst = 1'b0;

        for (int i = 1; i <= FW; i++) push(i);

        // FILL: requests (even with frame_start) are not served
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 2), 1'b0, 24'h0, 1'b0);
            #1 chk("fill_fifo_read", {31'd0, fifo_read}, 32'd0);
            step();
        end
        chk("fill_untouched", rd_ptr, 0);

        // WAIT_FRAME: requests without frame_start are not served
        fifo_ralmost_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
            #1 chk("wait_fifo_read", {31'd0, fifo_read}, 32'd0);
            step();
        end
        chk("wait_untouched", rd_ptr, 0);

        // full frame of 0x000001..0x000020
        run_frame(FW, 1'b0, 1'b0);

        // underflow after 10 pixels, clr_err in the same cycle (set wins)
        repeat (10) push($urandom);
        run_frame(FW, 1'b0, 1'b1);
        drain_chk(FW - 10, 3);

        // frame_start and first request together from WAIT_FRAME
        repeat (FW - 3) push($urandom);
        run_frame(FW, 1'b1, 1'b0);

        // clear the sticky flag
        drive(1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
        step();

        // three more underflowed frames at random points
        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(1, FW - 1);
            repeat (n) push($urandom);
            run_frame(FW, bit'($urandom_range(0, 1)), 1'b0);
            drain_chk(FW - n, 0);
        end
`ifdef VGA_FEEDER_STATS_EN
        chk("underflow_cnt_3", {16'd0, underflow_cnt}, 32'd3);
`endif
        drive(1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
        step();

        // reset in the middle of a streamed frame
        repeat (FW) push($urandom);
        run_frame(5, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
        #1 chk("pre_rst_fifo_read", {31'd0, fifo_read}, 32'd1);
        #1 pixel_rst = 1'b1;
        #1;
        chk("midrst_rgb", {8'd0, rgb}, 32'd0);
        chk("midrst_rgb_valid", {31'd0, rgb_valid}, 32'd0);
        chk("midrst_fifo_read", {31'd0, fifo_read}, 32'd0);
        pix_req = 1'b0;
        prev_req = 1'b0; prev_exp = '0; exp_uf = 1'b0;
`ifdef VGA_FEEDER_STATS_EN
        exp_cnt = 0;
`endif
        @(posedge pixel_clk);
        #1;
        fifo_ralmost_full = 1'b0;
        pixel_rst = 1'b0;
        wr_ptr = rd_ptr;
        for (int i = 0; i < FW; i++) push(32'h100 + i);
        n = rd_ptr;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
            #1 chk("postrst_fifo_read", {31'd0, fifo_read}, 32'd0);
            step();
        end
        chk("postrst_untouched", rd_ptr, n);
        fifo_ralmost_full = 1'b1;
        idle(2);
        run_frame(FW, bit'($urandom_range(0, 1)), 1'b0);
        idle(2);

        chk("bad_pop", bad_pop, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
